// File: rtl/ariane_pkg.sv
// Shared widths, privilege/mode encodings and the commit trace entry layout.
package ariane_pkg;

  localparam int VLEN        = 64;
  localparam int XLEN        = 64;
  localparam int PLEN        = 56;
  localparam int TraceCycleW = 32;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Debug mode reuses the reserved privilege code so the field stays 2 bits.
  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_D = 2'b10;
  localparam logic [1:0] MODE_M = 2'b11;

  localparam int MASK_M = 0;
  localparam int MASK_S = 1;
  localparam int MASK_U = 2;
  localparam int MASK_D = 3;

  typedef struct packed {
    logic [TraceCycleW-1:0] cycle;
    logic [VLEN-1:0]        pc;
    logic [31:0]            instr;
    logic [4:0]             rd;
    logic                   fpr;
    logic [XLEN-1:0]        wdata;
    logic                   is_exc;
    logic [XLEN-1:0]        cause;
    logic [1:0]             mode;
  } trace_entry_t;

  function automatic logic [1:0] mode_of(input logic dbg, input logic [1:0] priv);
    if (dbg)                 return MODE_D;
    else if (priv == PRIV_M) return MODE_M;
    else if (priv == PRIV_S) return MODE_S;
    else                     return MODE_U;
  endfunction

  function automatic int mask_bit(input logic [1:0] mode);
    case (mode)
      MODE_M:  return MASK_M;
      MODE_S:  return MASK_S;
      MODE_D:  return MASK_D;
      default: return MASK_U;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo_multi.sv
// Depth-entry FIFO accepting up to NrPorts pre-compacted writes per cycle, one read.
// Head is read combinationally; flush empties it on the next edge.
module trace_fifo_multi
  import ariane_pkg::*;
#(
  parameter int Depth   = 16,
  parameter int NrPorts = 2,
  parameter int CntW    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [CntW-1:0]          wr_cnt_i,
  input  trace_entry_t             wr_dat_i [NrPorts],
  input  logic                     pop_i,
  output trace_entry_t             rd_dat_o,
  output logic [$clog2(Depth):0]   fill_o
);

  localparam int PtrW = $clog2(Depth);

  trace_entry_t            mem [Depth];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [PtrW:0]           fill_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NrPorts; k++) begin
      if (!flush_i && (CntW'(k) < wr_cnt_i))
        mem[wptr_q + PtrW'(k)] <= wr_dat_i[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else if (flush_i) begin
      rptr_q <= wptr_q;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_q + PtrW'(wr_cnt_i);
      rptr_q <= rptr_q + PtrW'(pop_i);
      fill_q <= fill_q + (PtrW+1)'(wr_cnt_i) - (PtrW+1)'(pop_i);
    end
  end

  assign rd_dat_o = mem[rptr_q];
  assign fill_o   = fill_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Filters retired/excepting instructions by mode and cause, stamps them and queues them for drain.
// Captures in the commit cycle; overflow drops from the highest port and is counted.
module commit_trace_buffer
  import ariane_pkg::*;
#(
  parameter int          NrCommitPorts = 2,
  parameter int          Depth         = 16,
  parameter int          CycleWidth    = 32,
  parameter logic [63:0] ToHostAddr    = 64'h8000_1000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic [3:0]                mode_mask_i,
  input  logic [1:0]                priv_lvl_i,
  input  logic                      debug_mode_i,
  input  logic [NrCommitPorts-1:0]  commit_ack_i,
  input  logic [NrCommitPorts-1:0]  commit_ex_i,
  input  logic                      ex_commit_i,
  input  logic [VLEN-1:0]           commit_pc_i    [NrCommitPorts],
  input  logic [31:0]               commit_instr_i [NrCommitPorts],
  input  logic [4:0]                commit_rd_i    [NrCommitPorts],
  input  logic [NrCommitPorts-1:0]  commit_fpr_i,
  input  logic [XLEN-1:0]           commit_wdata_i [NrCommitPorts],
  input  logic [XLEN-1:0]           commit_cause_i [NrCommitPorts],
  input  logic                      st_req_i,
  input  logic [PLEN-1:0]           st_addr_i,
  input  logic [63:0]               st_data_i,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output trace_entry_t              trace_entry_o,
  output logic [$clog2(Depth):0]    fill_o,
  output logic [15:0]               drop_cnt_o,
  output logic                      tohost_hit_o,
  output logic [63:0]               tohost_data_o,
  output logic [CycleWidth-1:0]     cycle_o
);

  localparam int CntW = $clog2(NrCommitPorts + 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] PAUSE = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [CycleWidth-1:0]    cycle_q;
  logic [15:0]              drop_q;
  logic [16:0]              drop_sum;
  logic                     hit_q;
  logic [63:0]              hit_dat_q;
  logic [1:0]               mode;
  logic                     capture, pop, tohost_st;
  logic [NrCommitPorts-1:0] is_exc, keep;
  trace_entry_t             cand   [NrCommitPorts];
  trace_entry_t             wr_dat [NrCommitPorts];
  logic [CntW-1:0]          wr_cnt, drop_num;

  assign capture   = (state_q == RUN) && !flush_i;
  assign pop       = trace_valid_o && trace_ready_i && !flush_i;
  assign tohost_st = st_req_i && (st_addr_i == ToHostAddr[PLEN-1:0]) && (state_q != HALT);
  assign mode      = mode_of(debug_mode_i, priv_lvl_i);

  always_comb begin
    for (int i = 0; i < NrCommitPorts; i++) begin
      is_exc[i] = commit_ex_i[i] && ex_commit_i;
      cand[i]   = '{cycle:  TraceCycleW'(cycle_q),
                    pc:     commit_pc_i[i],
                    instr:  commit_instr_i[i],
                    rd:     commit_rd_i[i],
                    fpr:    commit_fpr_i[i],
                    wdata:  commit_wdata_i[i],
                    is_exc: is_exc[i],
                    cause:  commit_cause_i[i],
                    mode:   mode};
      keep[i]   = capture && (commit_ack_i[i] || is_exc[i])
               && mode_mask_i[mask_bit(mode)]
               && !(is_exc[i] && (commit_cause_i[i] == XLEN'(2)))
               && !(!debug_mode_i && (commit_cause_i[i] == XLEN'(24)));
    end
  end

  // Kept candidates pack into slots 0..n-1; anything past the free space is dropped.
  always_comb begin
    int n, d, free_n;
    n      = 0;
    d      = 0;
    free_n = Depth - int'(fill_o) + int'(pop);
    for (int k = 0; k < NrCommitPorts; k++) wr_dat[k] = cand[k];
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (keep[i]) begin
        if (n < free_n) begin
          for (int k = 0; k < NrCommitPorts; k++)
            if (k == n) wr_dat[k] = cand[i];
          n = n + 1;
        end else begin
          d = d + 1;
        end
      end
    end
    wr_cnt   = CntW'(n);
    drop_num = CntW'(d);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!enable_i) state_d = PAUSE;
      PAUSE:   if (enable_i)  state_d = RUN;
      default: state_d = HALT;
    endcase
    if (tohost_st) state_d = HALT;
  end

  assign drop_sum = {1'b0, drop_q} + 17'(drop_num);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      cycle_q   <= '0;
      drop_q    <= '0;
      hit_q     <= 1'b0;
      hit_dat_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_q + 1'b1;
      drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (tohost_st) begin
        hit_q     <= 1'b1;
        hit_dat_q <= st_data_i;
      end
    end
  end

  trace_fifo_multi #(
    .Depth   (Depth),
    .NrPorts (NrCommitPorts),
    .CntW    (CntW)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .wr_cnt_i (wr_cnt),
    .wr_dat_i (wr_dat),
    .pop_i    (pop),
    .rd_dat_o (trace_entry_o),
    .fill_o   (fill_o)
  );

  assign trace_valid_o = (fill_o != '0);
  assign drop_cnt_o    = drop_q;
  assign tohost_hit_o  = hit_q;
  assign tohost_data_o = hit_dat_q;
  assign cycle_o       = cycle_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with hand-computed expectations.
module tb_commit_trace_buffer;
  import ariane_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable, flush, debug, ex_commit, st_req, ready;
  logic [3:0]       mask;
  logic [1:0]       priv;
  logic [1:0]       ack, ex, fpr;
  logic [63:0]      pc [2], wdata [2], cause [2];
  logic [31:0]      instr [2];
  logic [4:0]       rd [2];
  logic [PLEN-1:0]  st_addr;
  logic [63:0]      st_data;
  logic             valid, hit;
  trace_entry_t     te;
  logic [4:0]       fill;
  logic [15:0]      drops;
  logic [63:0]      hit_dat;
  logic [31:0]      cycle;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int stamp;

  always #5 clk = ~clk;

  commit_trace_buffer dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .mode_mask_i(mask), .priv_lvl_i(priv), .debug_mode_i(debug),
    .commit_ack_i(ack), .commit_ex_i(ex), .ex_commit_i(ex_commit),
    .commit_pc_i(pc), .commit_instr_i(instr), .commit_rd_i(rd),
    .commit_fpr_i(fpr), .commit_wdata_i(wdata), .commit_cause_i(cause),
    .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data),
    .trace_valid_o(valid), .trace_ready_i(ready), .trace_entry_o(te),
    .fill_o(fill), .drop_cnt_o(drops), .tohost_hit_o(hit),
    .tohost_data_o(hit_dat), .cycle_o(cycle)
  );

  task automatic check_dat(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    ack = '0; ex = '0; fpr = '0; ex_commit = 1'b0; st_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pc[i] = '0; wdata[i] = '0; cause[i] = '0; instr[i] = '0; rd[i] = '0;
    end
  endtask

  task automatic put(input int p, input logic [63:0] a, input logic [63:0] c);
    ack[p] = 1'b1; pc[p] = a; cause[p] = c;
    instr[p] = 32'h13 + 32'(p); rd[p] = 5'(p + 1); wdata[p] = a + 64'h1000;
  endtask

  task automatic drain_all();
    ready = 1'b1;
    for (int i = 0; i < 20 && valid; i++) step();
    ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; debug = 1'b0; ready = 1'b0;
    mask = 4'b1111; priv = PRIV_M; st_addr = '0; st_data = '0;
    clr();
    #2;
    check_dat("rst_valid", 64'(valid), 64'd0);
    check_dat("rst_fill",  64'(fill),  64'd0);
    check_dat("rst_cycle", 64'(cycle), 64'd0);
    check_dat("rst_drops", 64'(drops), 64'd0);
    check_dat("rst_hit",   64'(hit),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 0;

    // Two-port retire, drained in port order.
    step(); step();
    check_dat("cycle_count", 64'(cycle), 64'(cyc));
    stamp = cyc;
    put(0, 64'h100, 64'h0); put(1, 64'h104, 64'h0);
    step(); clr();
    check_dat("two_fill", 64'(fill), 64'd2);
    check_dat("two_pc0", te.pc, 64'h100);
    check_dat("two_cyc0", 64'(te.cycle), 64'(stamp));
    check_dat("two_mode", 64'(te.mode), 64'(MODE_M));
    check_dat("two_wdata0", te.wdata, 64'h1100);
    ready = 1'b1;
    step();
    check_dat("two_pc1", te.pc, 64'h104);
    check_dat("two_cyc1", 64'(te.cycle), 64'(stamp));
    check_dat("two_rd1", 64'(te.rd), 64'd2);
    step(); ready = 1'b0;
    check_dat("two_empty", 64'(fill), 64'd0);
    check_dat("two_valid", 64'(valid), 64'd0);

    // Exception cause filtering.
    ex[0] = 1'b1; ex_commit = 1'b1; cause[0] = 64'd2; pc[0] = 64'h200;
    step(); clr();
    check_dat("exc2_drop", 64'(fill), 64'd0);
    ex[0] = 1'b1; ex_commit = 1'b1; cause[0] = 64'd5; pc[0] = 64'h204;
    step(); clr();
    check_dat("exc5_fill", 64'(fill), 64'd1);
    check_dat("exc5_isexc", 64'(te.is_exc), 64'd1);
    check_dat("exc5_cause", te.cause, 64'd5);
    drain_all();
    put(0, 64'h208, 64'd24);
    step(); clr();
    check_dat("c24_drop", 64'(fill), 64'd0);
    debug = 1'b1;
    put(0, 64'h20C, 64'd24);
    step(); clr(); debug = 1'b0;
    check_dat("c24_dbg_fill", 64'(fill), 64'd1);
    check_dat("c24_dbg_mode", 64'(te.mode), 64'(MODE_D));
    drain_all();

    // Mode mask.
    mask = 4'b0001; priv = PRIV_U;
    put(0, 64'h300, 64'h0);
    step(); clr();
    check_dat("mask_u_drop", 64'(fill), 64'd0);
    priv = PRIV_M;
    put(0, 64'h304, 64'h0);
    step(); clr(); mask = 4'b1111;
    check_dat("mask_m_fill", 64'(fill), 64'd1);
    check_dat("mask_m_mode", 64'(te.mode), 64'(MODE_M));
    drain_all();

    // Fill to 15, then overflow by one, then full with simultaneous pop.
    for (int i = 0; i < 7; i++) begin
      put(0, 64'h400 + 64'(16*i), 64'h0); put(1, 64'h408 + 64'(16*i), 64'h0);
      step(); clr();
    end
    put(0, 64'h470, 64'h0);
    step(); clr();
    check_dat("fill15", 64'(fill), 64'd15);
    put(0, 64'hA0, 64'h0); put(1, 64'hA4, 64'h0);
    step(); clr();
    check_dat("full_fill", 64'(fill), 64'd16);
    check_dat("full_drop", 64'(drops), 64'd1);
    ready = 1'b1;
    put(0, 64'hB0, 64'h0); put(1, 64'hB4, 64'h0);
    step(); clr();
    check_dat("fullpop_fill", 64'(fill), 64'd16);
    check_dat("fullpop_drop", 64'(drops), 64'd2);
    check_dat("fullpop_head", te.pc, 64'h408);
    for (int i = 0; i < 14; i++) step();
    check_dat("wrap_head_a0", te.pc, 64'hA0);
    step();
    check_dat("wrap_head_b0", te.pc, 64'hB0);
    step(); ready = 1'b0;
    check_dat("wrap_empty", 64'(fill), 64'd0);

    // Pause blocks capture, resume restores it.
    enable = 1'b0;
    step();
    put(0, 64'h500, 64'h0);
    step(); clr();
    check_dat("pause_drop", 64'(fill), 64'd0);
    enable = 1'b1;
    step();
    put(0, 64'h504, 64'h0);
    step(); clr();
    check_dat("resume_fill", 64'(fill), 64'd1);

    // Flush ignores same-cycle capture and keeps drop count.
    put(0, 64'h508, 64'h0);
    step(); clr();
    flush = 1'b1;
    put(0, 64'h50C, 64'h0); put(1, 64'h510, 64'h0);
    step(); clr(); flush = 1'b0;
    check_dat("flush_fill", 64'(fill), 64'd0);
    check_dat("flush_drops", 64'(drops), 64'd2);

    // Reset mid-drain with five entries.
    put(0, 64'h600, 64'h0); put(1, 64'h604, 64'h0); step(); clr();
    put(0, 64'h608, 64'h0); put(1, 64'h60C, 64'h0); step(); clr();
    put(0, 64'h610, 64'h0); step(); clr();
    check_dat("pre_rst_fill", 64'(fill), 64'd5);
    ready = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_dat("arst_valid", 64'(valid), 64'd0);
    check_dat("arst_fill", 64'(fill), 64'd0);
    check_dat("arst_drops", 64'(drops), 64'd0);
    ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 0;
    put(0, 64'h700, 64'h0);
    step(); clr();
    check_dat("post_rst_run", 64'(fill), 64'd1);
    check_dat("post_rst_cycle", 64'(cycle), 64'd1);

    // Tohost store halts capture; same-cycle commit kept, drain continues.
    put(0, 64'h800, 64'h0);
    st_req = 1'b1; st_addr = PLEN'(64'h8000_1000); st_data = 64'h1;
    step(); clr();
    check_dat("halt_hit", 64'(hit), 64'd1);
    check_dat("halt_data", hit_dat, 64'h1);
    check_dat("halt_same_cyc", 64'(fill), 64'd2);
    put(0, 64'h804, 64'h0); put(1, 64'h808, 64'h0);
    step(); clr();
    check_dat("halt_ignore", 64'(fill), 64'd2);
    enable = 1'b0; step(); enable = 1'b1; step();
    put(0, 64'h80C, 64'h0);
    step(); clr();
    check_dat("halt_sticky", 64'(fill), 64'd2);
    ready = 1'b1;
    check_dat("halt_head", te.pc, 64'h700);
    step();
    check_dat("halt_head2", te.pc, 64'h800);
    step(); ready = 1'b0;
    check_dat("halt_drained", 64'(valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter NrCommitPorts, default 2: number of commit ports captured per cycle.
REQ-002 SHALL have parameter Depth, default 16: trace FIFO entries; power of two, at least NrCommitPorts.
REQ-003 SHALL have parameter CycleWidth, default 32: cycle-stamp width.
REQ-004 SHALL have parameter ToHostAddr, default 'h8000_1000: physical address that halts capture.
REQ-005 SHALL have ports:
 clk_i  in  1  core clock
 rst_ni  in  1  asynchronous active-low reset
 enable_i  in  1  capture enable
 flush_i  in  1  discard all buffered entries
 mode_mask_i  in  4  capture mask {D,U,S,M}; bit set = mode captured
 priv_lvl_i  in  2  current privilege (riscv::priv_lvl_t)
 debug_mode_i  in  1  core in debug mode
 commit_ack_i  in  NrCommitPorts  instruction retired without exception
 commit_ex_i  in  NrCommitPorts  port carries an exception (valid only with ex_commit_i)
 ex_commit_i  in  1  exception taken this cycle
 commit_pc_i  in  NrCommitPorts x VLEN  PC per port
 commit_instr_i  in  NrCommitPorts x 32  instruction word (tval)
 commit_rd_i  in  NrCommitPorts x 5  destination register
 commit_fpr_i  in  NrCommitPorts  destination is FP register
 commit_wdata_i  in  NrCommitPorts x XLEN  writeback data
 commit_cause_i  in  NrCommitPorts x XLEN  exception cause
 st_req_i / st_addr_i / st_data_i  in  1 / PLEN / 64  host store request
 trace_valid_o / trace_ready_i  out / in  1 / 1  drain handshake
 trace_entry_o  out  trace_entry_t  head FIFO entry
 fill_o  out  clog2(Depth)+1  occupied entries
 drop_cnt_o  out  16  saturating count of dropped entries
 tohost_hit_o  out  1  sticky: tohost store seen
 tohost_data_o  out  64  data of that store
 cycle_o  out  CycleWidth  free-running cycle counter

Function
REQ-006 SHALL keep free-running cycle_o, +1 every cycle, wrapping at 2^CycleWidth; each entry stamped with its capture-cycle value.
REQ-007 SHALL form candidate on port i when commit_ack_i[i] (retire entry) or commit_ex_i[i] && ex_commit_i (exception entry).
REQ-008 SHALL discard exception candidates with cause 2, and non-debug-mode candidates with cause 24.
REQ-009 SHALL derive mode D if debug_mode_i, else M/S/U from priv_lvl_i; candidate kept only if matching mode_mask_i bit is 1.
REQ-010 SHALL write kept candidates in ascending port order into consecutive FIFO slots in the same cycle.
REQ-011 SHALL compute free space as Depth - fill_o + (trace_valid_o && trace_ready_i); candidates beyond it dropped from highest port down, drop_cnt_o += dropped count, saturating at 16'hFFFF.
REQ-012 SHALL present head entry combinationally from storage; pop on trace_valid_o && trace_ready_i; trace_valid_o = (fill_o != 0).
REQ-013 SHALL, on flush_i, set fill_o to 0 next cycle, ignore same-cycle captures and pop, leave drop_cnt_o and tohost state untouched.
REQ-014 SHALL implement FSM RUN, PAUSE, HALT: RUN->PAUSE when enable_i=0; PAUSE->RUN when enable_i=1; RUN/PAUSE->HALT on st_req_i with st_addr_i==ToHostAddr; HALT left only by reset.
REQ-015 SHALL capture only in RUN; draining continues in every state.
REQ-016 SHALL, on HALT entry, set tohost_hit_o=1 and latch st_data_i into tohost_data_o; commits in that same cycle still captured.
REQ-017 SHALL wrap read/write pointers modulo Depth; fill_o reaches exactly Depth when full.

Reset
REQ-018 SHALL, on rst_ni low, asynchronously clear pointers, fill_o, cycle_o, drop_cnt_o, tohost_hit_o, tohost_data_o and enter RUN; trace_valid_o=0.
REQ-019 SHALL NOT reset FIFO data storage.

Structure
REQ-020 SHALL place trace_entry_t {cycle, pc, instr, rd, fpr, wdata, is_exc, cause, mode} and mode-mask bit constants in ariane_pkg.
REQ-021 SHALL instantiate one sub-module, trace_fifo_multi, a Depth-entry FIFO with NrCommitPorts write ports and one read port.
REQ-022 SHALL be synthesizable; no file I/O or $finish inside.

Verification
REQ-023 Ports 0,1 ack, mask 4'b1111, ready=1 -> two entries in port order, cycle stamps equal, fill_o back to 0 after 2 pops.
REQ-024 Depth=16, ready=0, fill=15, both ports ack -> port 0 stored, fill_o=16, drop_cnt_o=1.
REQ-025 Port 0 exception cause 2 with ex_commit_i -> no entry; cause 5 -> entry with is_exc=1, cause=5.
REQ-026 mask 4'b0001, priv U commit -> no entry; priv M -> entry mode M.
REQ-027 Store to 'h8000_1000 data 'h1 -> tohost_hit_o=1, tohost_data_o='h1, later commits ignored, buffered entries still drain.
REQ-028 Reset asserted with fill=5 mid-drain -> trace_valid_o=0, fill_o=0, FSM RUN immediately.
